// File: rtl/mem_burst_arbiter.sv
// Arbitrates the DDR burst port between the frame-buffer writer and reader.
// Define MEM_ARB_WR_PRIORITY_EN for fixed write priority; default is round-robin.
module mem_burst_arbiter #(
   parameter int MEM_DATA_BITS = 64,
   parameter int ADDR_BITS     = 24
) (
   input  logic                     mem_clk,
   input  logic                     rst_n,
   input  logic                     wr_burst_req,
   input  logic [9:0]               wr_burst_len,
   input  logic [ADDR_BITS-1:0]     wr_burst_addr,
   output logic                     wr_burst_data_req,
   input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
   output logic                     wr_burst_finish,
   input  logic                     rd_burst_req,
   input  logic [9:0]               rd_burst_len,
   input  logic [ADDR_BITS-1:0]     rd_burst_addr,
   output logic                     rd_burst_data_valid,
   output logic [MEM_DATA_BITS-1:0] rd_burst_data,
   output logic                     rd_burst_finish,
   output logic                     mem_wr_burst_req,
   output logic                     mem_rd_burst_req,
   output logic [9:0]               mem_burst_len,
   output logic [ADDR_BITS-1:0]     mem_burst_addr,
   input  logic                     mem_wr_burst_data_req,
   output logic [MEM_DATA_BITS-1:0] mem_wr_burst_data,
   input  logic                     mem_rd_burst_data_valid,
   input  logic [MEM_DATA_BITS-1:0] mem_rd_burst_data,
   input  logic                     mem_burst_finish,
   output logic                     burst_err
);

   typedef enum logic [1:0] {IDLE, WR_GRANT, RD_GRANT, RELEASE} state_t;

   state_t               state_q, state_d;
   logic [9:0]           len_q, len_d;
   logic [9:0]           beat_q, beat_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic                 mem_wr_req_q, mem_wr_req_d;
   logic                 mem_rd_req_q, mem_rd_req_d;
   logic                 err_q, err_d;
   logic                 pick_wr;
   logic                 wr_gnt, rd_gnt, strobe, zero_len;

   assign wr_gnt   = (state_q == WR_GRANT);
   assign rd_gnt   = (state_q == RD_GRANT);
   assign strobe   = (wr_gnt & mem_wr_burst_data_req) | (rd_gnt & mem_rd_burst_data_valid);
   assign zero_len = (len_q == 10'd0);

`ifdef MEM_ARB_WR_PRIORITY_EN
   // Input capture cannot stall, so the writer always wins a tie.
   assign pick_wr = wr_burst_req;
`else
   logic last_wr_q, last_wr_d;  // 1: write was served most recently
   logic gnt_wr_q, gnt_wr_d;

   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         last_wr_q <= 1'b0;
         gnt_wr_q  <= 1'b0;
      end else begin
         last_wr_q <= last_wr_d;
         gnt_wr_q  <= gnt_wr_d;
      end
   end

   always_comb begin
      last_wr_d = last_wr_q;
      gnt_wr_d  = gnt_wr_q;
      if (state_q == IDLE && (wr_burst_req | rd_burst_req)) gnt_wr_d = pick_wr;
      if (state_q == RELEASE) last_wr_d = gnt_wr_q;
   end

   assign pick_wr = wr_burst_req & (~rd_burst_req | ~last_wr_q);
`endif

   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         len_q        <= '0;
         beat_q       <= '0;
         addr_q       <= '0;
         mem_wr_req_q <= 1'b0;
         mem_rd_req_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
         addr_q       <= addr_d;
         mem_wr_req_q <= mem_wr_req_d;
         mem_rd_req_q <= mem_rd_req_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      beat_d       = beat_q;
      addr_d       = addr_q;
      mem_wr_req_d = mem_wr_req_q;
      mem_rd_req_d = mem_rd_req_q;
      err_d        = err_q;
      case (state_q)
         IDLE: begin
            beat_d = '0;
            if (wr_burst_req | rd_burst_req) begin
               if (pick_wr) begin
                  state_d      = WR_GRANT;
                  len_d        = wr_burst_len;
                  addr_d       = wr_burst_addr;
                  mem_wr_req_d = |wr_burst_len;
               end else begin
                  state_d      = RD_GRANT;
                  len_d        = rd_burst_len;
                  addr_d       = rd_burst_addr;
                  mem_rd_req_d = |rd_burst_len;
               end
            end
         end
         WR_GRANT, RD_GRANT: begin
            beat_d = beat_q + {9'd0, strobe};
            // Controller has accepted the burst once it strobes or finishes.
            if (strobe | mem_burst_finish) begin
               mem_wr_req_d = 1'b0;
               mem_rd_req_d = 1'b0;
            end
            if (mem_burst_finish) begin
               state_d = RELEASE;
               if (beat_d != len_q) err_d = 1'b1;
            end else if (zero_len) begin
               state_d = RELEASE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Zero-length bursts never reach memory; the arbiter finishes them itself.
   assign wr_burst_data_req   = mem_wr_burst_data_req & wr_gnt;
   assign rd_burst_data_valid = mem_rd_burst_data_valid & rd_gnt;
   assign wr_burst_finish     = wr_gnt & (mem_burst_finish | zero_len);
   assign rd_burst_finish     = rd_gnt & (mem_burst_finish | zero_len);
   assign rd_burst_data       = mem_rd_burst_data;
   assign mem_wr_burst_data   = wr_burst_data;
   assign mem_wr_burst_req    = mem_wr_req_q;
   assign mem_rd_burst_req    = mem_rd_req_q;
   assign mem_burst_len       = len_q;
   assign mem_burst_addr      = addr_q;
   assign burst_err           = err_q;

endmodule
